// File: rtl/mem_ctrl_write_buffer.sv
// -----------------------------------------------------------------------------
// mem_ctrl_write_buffer
//
// Block-writeback buffer for the memory controller. Whole cache blocks are
// accepted on the enqueue side, held in a circular FIFO of DEPTH entries and
// drained to word-wide RAM one word per ACCESS cycle. Buffered blocks are
// visible to read lookups so the controller can forward pending data without
// a RAM read.
//
// Optional feature macro: WRITE_BUFFER_COALESCE_EN
//   When defined, a writeback to an address already buffered in a non-head
//   entry overwrites that entry's data in place instead of allocating.
//
// Ports:
//   CLK, RST          clock; synchronous active-high reset
//   enq_valid/ready   block writeback handshake (enq_addr, enq_data)
//   lookup_valid      combinational lookup of lookup_addr -> lookup_hit/data
//   ram_wen           RAM write request; ram_addr = {block addr, word idx}
//   ram_wdata         word being written
//   ram_state         RAM handshake: FREE=0, BUSY=1, ACCESS=2, ERROR=3
//   count             occupied entries
//   error             sticky RAM error (cleared only by RST)
// -----------------------------------------------------------------------------
module mem_ctrl_write_buffer #(
  parameter int DEPTH            = 8,
  parameter int BLOCK_ADDR_WIDTH = 29,
  parameter int WORDS_PER_BLOCK  = 2,
  parameter int WORD_WIDTH       = 32,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int IDX_W  = $clog2(WORDS_PER_BLOCK),
  localparam int CNT_W  = PTR_W + 1,
  localparam int BLK_W  = WORDS_PER_BLOCK * WORD_WIDTH,
  localparam int RAM_AW = BLOCK_ADDR_WIDTH + IDX_W
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        enq_valid,
  output logic                        enq_ready,
  input  logic [BLOCK_ADDR_WIDTH-1:0] enq_addr,
  input  logic [BLK_W-1:0]            enq_data,
  input  logic                        lookup_valid,
  input  logic [BLOCK_ADDR_WIDTH-1:0] lookup_addr,
  output logic                        lookup_hit,
  output logic [BLK_W-1:0]            lookup_data,
  output logic                        ram_wen,
  output logic [RAM_AW-1:0]           ram_addr,
  output logic [WORD_WIDTH-1:0]       ram_wdata,
  input  logic [1:0]                  ram_state,
  output logic [CNT_W-1:0]            count,
  output logic                        error
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_ERR   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RAM_FREE   = 2'd0,
    RAM_BUSY   = 2'd1,
    RAM_ACCESS = 2'd2,
    RAM_ERROR  = 2'd3
  } ramstate_t;

  typedef logic [WORDS_PER_BLOCK-1:0][WORD_WIDTH-1:0] block_t;

  state_t                      state, state_next;
  ramstate_t                   ram_st;
  logic [PTR_W-1:0]            head_ptr, tail_ptr;
  logic [IDX_W-1:0]            word_idx;
  logic [CNT_W-1:0]            count_next;
  logic [DEPTH-1:0]            ent_valid;
  logic [BLOCK_ADDR_WIDTH-1:0] ent_addr [DEPTH];
  block_t                      ent_data [DEPTH];

  logic             full, last_word, word_ack, pop;
  logic             enq_fire, alloc, coal_hit;
  logic [PTR_W-1:0] coal_idx, lk_scan;

  assign ram_st    = ramstate_t'(ram_state);
  assign full      = (count == CNT_W'(DEPTH));
  assign last_word = (word_idx == IDX_W'(WORDS_PER_BLOCK - 1));
  assign word_ack  = (state == ST_WRITE) && (ram_st == RAM_ACCESS);
  assign pop       = word_ack && last_word;

  // Ready depends only on registered state; a pop in the same cycle does not
  // open a slot for a full buffer.
  assign enq_ready = (state != ST_ERR) && (!full || coal_hit);
  assign enq_fire  = enq_valid && enq_ready;
  assign alloc     = enq_fire && !coal_hit;

  // ---------------------------------------------------------------------------
  // Coalescing target search: youngest valid non-head entry with the same
  // address. The head is excluded because it may be partly written to RAM.
  // ---------------------------------------------------------------------------
`ifdef WRITE_BUFFER_COALESCE_EN
  logic [PTR_W-1:0] coal_scan;

  always_comb begin
    coal_hit  = 1'b0;
    coal_idx  = '0;
    coal_scan = '0;
    for (int k = 1; k < DEPTH; k++) begin
      coal_scan = head_ptr + PTR_W'(k);
      if (ent_valid[coal_scan] && (ent_addr[coal_scan] == enq_addr)) begin
        coal_hit = 1'b1;
        coal_idx = coal_scan;
      end
    end
  end
`else
  assign coal_hit = 1'b0;
  assign coal_idx = '0;
`endif

  always_comb begin
    count_next = count;
    case ({alloc, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Drain FSM
  // ---------------------------------------------------------------------------
  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned (which would infer a latch).
  always_comb begin
    state_next = state;
    ram_wen    = 1'b0;
    error      = 1'b0;
    case (state)
      // Uses the next count so a block enqueued into an empty buffer is
      // presented to RAM in the very next cycle.
      ST_IDLE: if (count_next != '0) state_next = ST_WRITE;
      ST_WRITE: begin
        ram_wen = 1'b1;
        if (ram_st == RAM_ERROR)            state_next = ST_ERR;
        else if (pop && count_next == '0)   state_next = ST_IDLE;
      end
      ST_ERR:  error = 1'b1;
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      head_ptr  <= '0;
      tail_ptr  <= '0;
      count     <= '0;
      word_idx  <= '0;
      ent_valid <= '0;
    end else begin
      count <= count_next;
      if (word_ack) word_idx <= last_word ? '0 : word_idx + IDX_W'(1);
      if (pop) begin
        head_ptr            <= head_ptr + PTR_W'(1);
        ent_valid[head_ptr] <= 1'b0;
      end
      // Allocation never targets the head while it pops: the tail only
      // equals the head when the buffer is empty or full.
      if (alloc) begin
        tail_ptr            <= tail_ptr + PTR_W'(1);
        ent_valid[tail_ptr] <= 1'b1;
      end
    end
  end

  // NOTE: entry address/data storage is deliberately not reset; the valid
  // bits alone decide whether an entry is meaningful.
  always_ff @(posedge CLK) begin
    if (alloc) begin
      ent_addr[tail_ptr] <= enq_addr;
      ent_data[tail_ptr] <= enq_data;
    end else if (enq_fire && coal_hit) begin
      ent_data[coal_idx] <= enq_data;
    end
  end

  // ---------------------------------------------------------------------------
  // RAM write port: head entry at the current word index, zero otherwise.
  // ---------------------------------------------------------------------------
  assign ram_addr  = (state == ST_WRITE) ? {ent_addr[head_ptr], word_idx} : '0;
  assign ram_wdata = (state == ST_WRITE) ? ent_data[head_ptr][word_idx] : '0;

  // ---------------------------------------------------------------------------
  // Lookup: scan oldest to youngest so the last match (closest to the tail)
  // wins. Only registered entries are seen.
  // ---------------------------------------------------------------------------
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    lk_scan     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      lk_scan = head_ptr + PTR_W'(k);
      if (lookup_valid && ent_valid[lk_scan] && (ent_addr[lk_scan] == lookup_addr)) begin
        lookup_hit  = 1'b1;
        lookup_data = ent_data[lk_scan];
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl_write_buffer.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl_write_buffer
//
// Self-checking bench for mem_ctrl_write_buffer (default parameters). Every
// accepted RAM word is compared against a scoreboard queue filled when the
// corresponding block is enqueued; scenario tasks add inline checks of
// count, handshake, lookup and error behaviour. Honours
// WRITE_BUFFER_COALESCE_EN when the design is built with it.
// -----------------------------------------------------------------------------
module tb_mem_ctrl_write_buffer;

  localparam int DEPTH = 8;
  localparam int BAW   = 29;
  localparam int WPB   = 2;
  localparam int WW    = 32;
  localparam int BLK_W = WPB * WW;
  localparam int RAW   = BAW + 1;
  localparam int CNT_W = 4;

  localparam logic [1:0] RS_FREE   = 2'd0;
  localparam logic [1:0] RS_BUSY   = 2'd1;
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

`ifdef WRITE_BUFFER_COALESCE_EN
  localparam bit COALESCE = 1'b1;
`else
  localparam bit COALESCE = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             RST;
  logic             enq_valid;
  logic             enq_ready;
  logic [BAW-1:0]   enq_addr;
  logic [BLK_W-1:0] enq_data;
  logic             lookup_valid;
  logic [BAW-1:0]   lookup_addr;
  logic             lookup_hit;
  logic [BLK_W-1:0] lookup_data;
  logic             ram_wen;
  logic [RAW-1:0]   ram_addr;
  logic [WW-1:0]    ram_wdata;
  logic [1:0]       ram_state;
  logic [CNT_W-1:0] count;
  logic             error;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [RAW-1:0] addr;
    logic [WW-1:0]  data;
  } wr_t;

  wr_t sb[$];

  always #5 CLK = ~CLK;

  mem_ctrl_write_buffer #(
    .DEPTH(DEPTH), .BLOCK_ADDR_WIDTH(BAW), .WORDS_PER_BLOCK(WPB), .WORD_WIDTH(WW)
  ) dut (
    .CLK(CLK), .RST(RST),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_addr(enq_addr), .enq_data(enq_data),
    .lookup_valid(lookup_valid), .lookup_addr(lookup_addr),
    .lookup_hit(lookup_hit), .lookup_data(lookup_data),
    .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_state(ram_state),
    .count(count), .error(error)
  );

  // One clock step. At the falling edge, a word the RAM will accept on the
  // coming rising edge is checked against the scoreboard.
  task automatic tick();
    wr_t exp;
    @(negedge CLK);
    if (ram_wen && ram_state == RS_ACCESS && !RST) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL ram_write_unexpected: got addr=%h data=%h, expected no write", ram_addr, ram_wdata);
      end else begin
        exp = sb.pop_front();
        if (ram_addr !== exp.addr || ram_wdata !== exp.data) begin
          errors++;
          $display("FAIL ram_write: got addr=%h data=%h, expected addr=%h data=%h",
                   ram_addr, ram_wdata, exp.addr, exp.data);
        end
      end
    end
    @(posedge CLK);
    #2;
  endtask

  task automatic push_block(input logic [BAW-1:0] a, input logic [BLK_W-1:0] d);
    for (int w = 0; w < WPB; w++) sb.push_back('{addr: {a, w[0]}, data: d[w*WW +: WW]});
  endtask

  task automatic do_enq(input logic [BAW-1:0] a, input logic [BLK_W-1:0] d, input bit push);
    enq_valid = 1'b1;
    enq_addr  = a;
    enq_data  = d;
    for (int i = 0; i < 50 && !enq_ready; i++) tick();
    checks++;
    if (!enq_ready) begin
      errors++;
      $display("FAIL enq_timeout: got enq_ready=0 for addr %h, expected 1 within 50 cycles", a);
      enq_valid = 1'b0;
    end else begin
      if (push) push_block(a, d);
      tick();
      enq_valid = 1'b0;
    end
  endtask

  task automatic drain_and_check(input string name);
    ram_state = RS_ACCESS;
    for (int i = 0; i < 200 && count != 0; i++) tick();
    ram_state = RS_FREE;
    checks++;
    if (count !== '0) begin
      errors++;
      $display("FAIL %s_drain_count: got %0d, expected 0", name, count);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain_words: got %0d words outstanding, expected 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; enq_valid = 1'b0; enq_addr = '0; enq_data = '0;
    lookup_valid = 1'b0; lookup_addr = '0; ram_state = RS_FREE;
    tick(); tick();
    RST = 1'b0; lookup_valid = 1'b1; lookup_addr = '0;
    #1;
    checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL rst_enq_ready: got %b, expected 1", enq_ready); end
    checks++; if (ram_wen !== 1'b0)   begin errors++; $display("FAIL rst_ram_wen: got %b, expected 0", ram_wen); end
    checks++; if (ram_addr !== '0)    begin errors++; $display("FAIL rst_ram_addr: got %h, expected 0", ram_addr); end
    checks++; if (ram_wdata !== '0)   begin errors++; $display("FAIL rst_ram_wdata: got %h, expected 0", ram_wdata); end
    checks++; if (count !== '0)       begin errors++; $display("FAIL rst_count: got %0d, expected 0", count); end
    checks++; if (error !== 1'b0)     begin errors++; $display("FAIL rst_error: got %b, expected 0", error); end
    checks++; if (lookup_hit !== 1'b0 || lookup_data !== '0) begin
      errors++; $display("FAIL rst_lookup: got hit=%b data=%h, expected 0/0", lookup_hit, lookup_data);
    end
    lookup_valid = 1'b0;
  endtask

  task automatic test_basic_drain();
    ram_state = RS_FREE;
    do_enq(29'h10, {32'hB, 32'hA}, 1'b1);
    checks++; if (ram_wen !== 1'b1 || ram_addr !== 30'h20 || ram_wdata !== 32'hA) begin
      errors++; $display("FAIL basic_first_word: got wen=%b addr=%h data=%h, expected 1/20/a", ram_wen, ram_addr, ram_wdata);
    end
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL basic_count: got %0d, expected 1", count); end
    tick();
    checks++; if (ram_wen !== 1'b1 || ram_addr !== 30'h20) begin
      errors++; $display("FAIL basic_hold: got wen=%b addr=%h, expected 1/20", ram_wen, ram_addr);
    end
    ram_state = RS_ACCESS;
    tick();
    checks++; if (ram_addr !== 30'h21 || ram_wdata !== 32'hB) begin
      errors++; $display("FAIL basic_second_word: got addr=%h data=%h, expected 21/b", ram_addr, ram_wdata);
    end
    tick();
    ram_state = RS_FREE;
    checks++; if (count !== '0 || ram_wen !== 1'b0 || ram_addr !== '0) begin
      errors++; $display("FAIL basic_done: got count=%0d wen=%b addr=%h, expected 0/0/0", count, ram_wen, ram_addr);
    end
  endtask

  task automatic test_fill_wrap();
    ram_state = RS_BUSY;
    for (int i = 0; i < DEPTH; i++) do_enq(BAW'(29'h100 + i), {$urandom, $urandom}, 1'b1);
    checks++; if (count !== 4'd8 || enq_ready !== 1'b0) begin
      errors++; $display("FAIL fill_full: got count=%0d ready=%b, expected 8/0", count, enq_ready);
    end
    ram_state = RS_ACCESS; tick(); tick(); ram_state = RS_BUSY;
    checks++; if (count !== 4'd7 || enq_ready !== 1'b1) begin
      errors++; $display("FAIL fill_one_popped: got count=%0d ready=%b, expected 7/1", count, enq_ready);
    end
    for (int i = 0; i < 10; i++) begin
      do_enq(BAW'(29'h200 + i), {$urandom, $urandom}, 1'b1);
      ram_state = RS_ACCESS; tick(); tick(); ram_state = RS_BUSY;
      checks++; if (count !== 4'd7) begin
        errors++; $display("FAIL wrap_count_%0d: got %0d, expected 7", i, count);
      end
    end
    drain_and_check("wrap");
  endtask

  task automatic test_duplicate();
    logic [BLK_W-1:0] h, d1, d2;
    h  = {32'h0303_0001, 32'h0303_0000};
    d1 = {32'hD1D1_0001, 32'hD1D1_0000};
    d2 = {32'hD2D2_0001, 32'hD2D2_0000};
    ram_state = RS_BUSY;
    do_enq(29'h3, h, 1'b1);
    do_enq(29'h5, d1, !COALESCE);
    do_enq(29'h5, d2, 1'b1);
    checks++; if (count !== (COALESCE ? 4'd2 : 4'd3)) begin
      errors++; $display("FAIL dup_count: got %0d, expected %0d", count, COALESCE ? 2 : 3);
    end
    lookup_valid = 1'b1; lookup_addr = 29'h5; #1;
    checks++; if (lookup_hit !== 1'b1 || lookup_data !== d2) begin
      errors++; $display("FAIL dup_lookup: got hit=%b data=%h, expected 1/%h", lookup_hit, lookup_data, d2);
    end
    lookup_addr = 29'h3; #1;
    checks++; if (lookup_hit !== 1'b1 || lookup_data !== h) begin
      errors++; $display("FAIL dup_lookup_head: got hit=%b data=%h, expected 1/%h", lookup_hit, lookup_data, h);
    end
    lookup_valid = 1'b0;
    drain_and_check("dup");
  endtask

  task automatic test_lookup_timing();
    logic [BLK_W-1:0] d;
    d = {32'h7777_0001, 32'h7777_0000};
    ram_state = RS_BUSY;
    lookup_valid = 1'b1; lookup_addr = 29'h7; #1;
    checks++; if (lookup_hit !== 1'b0 || lookup_data !== '0) begin
      errors++; $display("FAIL lookup_miss: got hit=%b data=%h, expected 0/0", lookup_hit, lookup_data);
    end
    enq_valid = 1'b1; enq_addr = 29'h7; enq_data = d; #1;
    checks++; if (lookup_hit !== 1'b0 || enq_ready !== 1'b1) begin
      errors++; $display("FAIL lookup_same_cycle: got hit=%b ready=%b, expected 0/1", lookup_hit, enq_ready);
    end
    push_block(29'h7, d);
    tick();
    enq_valid = 1'b0; #1;
    checks++; if (lookup_hit !== 1'b1 || lookup_data !== d) begin
      errors++; $display("FAIL lookup_next_cycle: got hit=%b data=%h, expected 1/%h", lookup_hit, lookup_data, d);
    end
    lookup_valid = 1'b0; #1;
    checks++; if (lookup_hit !== 1'b0 || lookup_data !== '0) begin
      errors++; $display("FAIL lookup_invalid: got hit=%b data=%h, expected 0/0", lookup_hit, lookup_data);
    end
    drain_and_check("lookup");
  endtask

  task automatic test_error();
    ram_state = RS_BUSY;
    do_enq(29'h20, {32'hE1, 32'hE0}, 1'b0);
    ram_state = RS_ERROR; tick(); ram_state = RS_FREE;
    checks++; if (error !== 1'b1 || ram_wen !== 1'b0 || enq_ready !== 1'b0 || ram_addr !== '0) begin
      errors++; $display("FAIL err_enter: got error=%b wen=%b ready=%b addr=%h, expected 1/0/0/0", error, ram_wen, enq_ready, ram_addr);
    end
    ram_state = RS_ACCESS; enq_valid = 1'b1; enq_addr = 29'h21;
    tick(); tick(); tick();
    enq_valid = 1'b0; ram_state = RS_FREE;
    checks++; if (error !== 1'b1 || ram_wen !== 1'b0 || enq_ready !== 1'b0 || count !== 4'd1) begin
      errors++; $display("FAIL err_sticky: got error=%b wen=%b ready=%b count=%0d, expected 1/0/0/1", error, ram_wen, enq_ready, count);
    end
    lookup_valid = 1'b1; lookup_addr = 29'h20; #1;
    checks++; if (lookup_hit !== 1'b1 || lookup_data !== {32'hE1, 32'hE0}) begin
      errors++; $display("FAIL err_lookup: got hit=%b data=%h, expected 1/e1_e0", lookup_hit, lookup_data);
    end
    RST = 1'b1; tick(); RST = 1'b0; #1;
    checks++; if (error !== 1'b0 || enq_ready !== 1'b1 || count !== '0 || ram_wen !== 1'b0) begin
      errors++; $display("FAIL err_reset: got error=%b ready=%b count=%0d wen=%b, expected 0/1/0/0", error, enq_ready, count, ram_wen);
    end
    checks++; if (lookup_hit !== 1'b0 || lookup_data !== '0) begin
      errors++; $display("FAIL err_reset_lookup: got hit=%b data=%h, expected 0/0", lookup_hit, lookup_data);
    end
    lookup_valid = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset_mid_drain();
    logic [BLK_W-1:0] da, db;
    da = {32'hA401, 32'hA400};
    db = {32'hB411, 32'hB410};
    ram_state = RS_FREE;
    do_enq(29'h40, da, 1'b1);
    ram_state = RS_ACCESS; tick();
    RST = 1'b1; ram_state = RS_FREE; tick(); RST = 1'b0;
    checks++; if (count !== '0 || ram_wen !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got count=%0d wen=%b, expected 0/0", count, ram_wen);
    end
    sb.delete();
    do_enq(29'h41, db, 1'b1);
    checks++; if (ram_addr !== 30'h82 || ram_wdata !== 32'hB410) begin
      errors++; $display("FAIL mid_reset_restart: got addr=%h data=%h, expected 82/b410", ram_addr, ram_wdata);
    end
    drain_and_check("mid_reset");
  endtask

  initial begin
    test_reset();
    test_basic_drain();
    test_fill_wrap();
    test_duplicate();
    test_lookup_timing();
    test_error();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
